// File: rtl/axi_llc_arcane_lock_req_if.sv
// Software lock-write handshake and arcane-FSM lock request/grant signals.
interface axi_llc_arcane_lock_req_if;
    logic sw_wr_valid_i;
    logic sw_wr_data_i;
    logic sw_wr_ready_o;
    logic ecpu_lock_o;
    logic ecpu_lock_req_o;
    logic ready_lock_i;
    logic done_o;
    logic busy_o;
    logic err_o;
    logic err_clr_i;

    modport slave (
        input  sw_wr_valid_i, sw_wr_data_i, ready_lock_i, err_clr_i,
        output sw_wr_ready_o, ecpu_lock_o, ecpu_lock_req_o, done_o, busy_o, err_o
    );

    modport master (
        output sw_wr_valid_i, sw_wr_data_i, ready_lock_i, err_clr_i,
        input  sw_wr_ready_o, ecpu_lock_o, ecpu_lock_req_o, done_o, busy_o, err_o
    );
endinterface

// File: rtl/axi_llc_arcane_lock_req.sv
// Software-driven lock bit with request/grant handshake to the arcane FSM.
// Optional grant timeout with sticky error: define ARCANE_LOCK_TIMEOUT_EN.
module axi_llc_arcane_lock_req #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    axi_llc_arcane_lock_req_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   lock_q, lock_d;
    logic   req_q, req_d;
    logic   done_q, done_d;
    logic   wr_acc;

`ifdef ARCANE_LOCK_TIMEOUT_EN
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout;

    assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    logic unused_err_clr;
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign unused_err_clr = bus.err_clr_i;
`endif

    assign wr_acc = bus.sw_wr_valid_i && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        req_d   = 1'b0;
        done_d  = 1'b0;
`ifdef ARCANE_LOCK_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    // Redundant acquire/release completes without bothering the arcane FSM
                    if (bus.sw_wr_data_i == lock_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
`ifdef ARCANE_LOCK_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            REQ: begin
                // Lock toggle and request drop share one edge; grant beats timeout
                if (bus.ready_lock_i) begin
                    lock_d  = ~lock_q;
                    state_d = DONE;
                    done_d  = 1'b1;
`ifdef ARCANE_LOCK_TIMEOUT_EN
                end else if (timeout) begin
                    state_d = ERR;
                    err_d   = 1'b1;
`endif
                end else begin
                    req_d   = 1'b1;
`ifdef ARCANE_LOCK_TIMEOUT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
`ifdef ARCANE_LOCK_TIMEOUT_EN
                if (bus.err_clr_i) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

`ifdef ARCANE_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.sw_wr_ready_o   = (state_q == IDLE);
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.ecpu_lock_o     = lock_q;
    assign bus.ecpu_lock_req_o = req_q;
    assign bus.done_o          = done_q;

endmodule
